// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared constants and helpers for the letter reaction game.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ARM    = 3'd1;
  localparam state_t PROMPT = 3'd2;
  localparam state_t HIT    = 3'd3;
  localparam state_t MISS   = 3'd4;

  localparam int NUM_LETTERS = 26;

  localparam logic [1:0] DISP_SCORE  = 2'd0;
  localparam logic [1:0] DISP_LETTER = 2'd1;
  localparam logic [1:0] DISP_LOSS   = 2'd2;
  localparam logic [1:0] DISP_HIT    = 2'd3;

  localparam int MS_W        = 11;
  localparam int ARM_BASE_MS = 250;

  // Fold a 5-bit random value into A-Z and bump it if it repeats the previous goal.
  function automatic logic [4:0] next_goal(input logic [4:0] raw, input logic [4:0] prev);
    logic [4:0] c;
    c = (raw >= 5'(NUM_LETTERS)) ? raw - 5'(NUM_LETTERS) : raw;
    if (c == prev) begin
      c = (c == 5'(NUM_LETTERS - 1)) ? 5'd0 : c + 5'd1;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/round_sequencer_if.sv
// ============================================================================
// Module   : round_sequencer_if
// Purpose  : Keyboard strobes in, display/timer controls and scores out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface round_sequencer_if;
  import game_pkg::*;

  logic            start;
  logic            key_valid;
  logic [4:0]      key_code;
  logic [4:0]      goal_letter;
  logic            goal_show;
  logic [1:0]      disp_sel;
  logic            timer_en;
  logic            timer_clr;
  logic [7:0]      score;
  logic [MS_W-1:0] last_ms;
  logic [MS_W-1:0] best_ms;
  logic            round_done;
  logic [2:0]      state_dbg;

  modport master (
    output start, key_valid, key_code,
    input  goal_letter, goal_show, disp_sel, timer_en, timer_clr,
    input  score, last_ms, best_ms, round_done, state_dbg
  );

  modport slave (
    input  start, key_valid, key_code,
    output goal_letter, goal_show, disp_sel, timer_en, timer_clr,
    output score, last_ms, best_ms, round_done, state_dbg
  );

endinterface

`default_nettype wire

// File: rtl/lfsr16_gen.sv
// ============================================================================
// Module   : lfsr16_gen
// Purpose  : Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/round_sequencer.sv
// ============================================================================
// Module   : round_sequencer
// Purpose  : One reaction-game round: random arm delay, prompt, judge, score.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_sequencer
  import game_pkg::*;
#(
  parameter int          TICK_DIV   = 100000,
  parameter int          TIMEOUT_MS = 2000,
  parameter int          HOLD_MS    = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  round_sequencer_if.slave  sif
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] MS_SAT    = '1;
  localparam logic [MS_W-1:0] TIMEOUT_C = MS_W'(TIMEOUT_MS);
  localparam logic [MS_W-1:0] HOLD_C    = MS_W'(HOLD_MS);

  logic [15:0]     lfsr;
  logic            unused_lfsr;
  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [MS_W-1:0] ms_q, ms_d, ms_inc;
  logic [MS_W-1:0] hold_q, hold_d, hold_inc;
  logic [MS_W-1:0] delay_q, delay_d;
  logic [MS_W-1:0] last_q, last_d, best_q, best_d;
  logic [4:0]      goal_q, goal_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      disp_q, disp_d;
  logic            show_q, show_d, ten_q, ten_d, clr_q, clr_d, done_q, done_d;
  logic            tick, enter;

  lfsr16_gen #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:9];

  assign tick     = (presc_q == PRESC_MAX);
  assign ms_inc   = (tick && ms_q != MS_SAT) ? ms_q + MS_W'(1) : ms_q;
  assign hold_inc = (tick && hold_q != MS_SAT) ? hold_q + MS_W'(1) : hold_q;

  // Thresholds compare against the post-tick count so a tick and a key in the same cycle agree.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sif.start) state_d = ARM;
      ARM:     if (sif.key_valid) state_d = MISS;
               else if (ms_inc >= delay_q) state_d = PROMPT;
      PROMPT:  if (sif.key_valid) state_d = (sif.key_code == goal_q) ? HIT : MISS;
               else if (ms_inc >= TIMEOUT_C) state_d = MISS;
      HIT:     if (hold_inc >= HOLD_C) state_d = ARM;
      MISS:    if (hold_inc >= HOLD_C) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter = (state_d != state_q);

  always_comb begin
    presc_d = enter ? '0 : (tick ? '0 : presc_q + PW'(1));
    ms_d    = enter ? '0 : ((state_q == ARM || state_q == PROMPT) ? ms_inc : ms_q);
    hold_d  = enter ? '0 : ((state_q == HIT || state_q == MISS) ? hold_inc : hold_q);
  end

  always_comb begin
    goal_d  = goal_q;
    delay_d = delay_q;
    score_d = score_q;
    last_d  = last_q;
    best_d  = best_q;
    if (enter && state_d == ARM) begin
      delay_d = MS_W'(ARM_BASE_MS) + MS_W'(lfsr[8:0]);
      goal_d  = next_goal(lfsr[4:0], goal_q);
      if (state_q == IDLE) begin
        score_d = '0;
      end
    end
    if (enter && state_d == HIT) begin
      last_d = ms_inc;
      if (ms_inc < best_q) begin
        best_d = ms_inc;
      end
      if (score_q != 8'hFF) begin
        score_d = score_q + 8'd1;
      end
    end
  end

  always_comb begin
    case (state_d)
      PROMPT:  disp_d = DISP_LETTER;
      HIT:     disp_d = DISP_HIT;
      MISS:    disp_d = DISP_LOSS;
      default: disp_d = DISP_SCORE;
    endcase
    show_d = (state_d == PROMPT);
    ten_d  = (state_d == PROMPT);
    clr_d  = enter && (state_d == PROMPT);
    done_d = enter && (state_d == HIT || state_d == MISS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      ms_q    <= '0;
      hold_q  <= '0;
      delay_q <= '0;
      goal_q  <= '0;
      score_q <= '0;
      last_q  <= '0;
      best_q  <= MS_SAT;
      disp_q  <= DISP_SCORE;
      show_q  <= 1'b0;
      ten_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      hold_q  <= hold_d;
      delay_q <= delay_d;
      goal_q  <= goal_d;
      score_q <= score_d;
      last_q  <= last_d;
      best_q  <= best_d;
      disp_q  <= disp_d;
      show_q  <= show_d;
      ten_q   <= ten_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign sif.goal_letter = goal_q;
  assign sif.goal_show   = show_q;
  assign sif.disp_sel    = disp_q;
  assign sif.timer_en    = ten_q;
  assign sif.timer_clr   = clr_q;
  assign sif.score       = score_q;
  assign sif.last_ms     = last_q;
  assign sif.best_ms     = best_q;
  assign sif.round_done  = done_q;
  assign sif.state_dbg   = state_q;

endmodule

`default_nettype wire

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Controls one reaction-game round on the Basys 3 letter game. It picks a pseudo-random goal letter and waits a random arming delay, then runs a millisecond reaction timer.
- It judges each keyboard press as hit, wrong key, false start or timeout, and keeps the score, streak and best time.
- It sits between the keyboard front end (one-cycle make strobes) and the display mux/timer datapath, driving their select and enable lines.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock).
- TIMEOUT_MS, 2000, reaction window in ms; must be < 2047.
- HOLD_MS, 1000, duration of the result display.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse (debounced button); begins a game from IDLE.
- key_valid  in  1  one-cycle strobe: a new key was made; key_code is valid this cycle.
- key_code  in  5  letter code 0-25 = A-Z; values 26-31 count as wrong keys.
- goal_letter  out  5  current goal letter, 0-25.
- goal_show  out  1  high while goal_letter must be displayed.
- disp_sel  out  2  display mux select: 0 score, 1 letter, 2 loss, 3 hit.
- timer_en  out  1  high while the reaction timer runs.
- timer_clr  out  1  one-cycle pulse when a prompt starts.
- score  out  8  rounds won in the current game; saturates at 255.
- last_ms  out  11  reaction time of the last hit.
- best_ms  out  11  best hit time since reset.
- round_done  out  1  one-cycle pulse on entry to HIT or MISS.
- state_dbg  out  3  current state encoding, for LEDs.

Behaviour:
- Reset values:
  - state IDLE, goal_letter 0, goal_show 0, disp_sel 0, timer_en 0, timer_clr 0.
  - score 0, last_ms 0, best_ms 2047, round_done 0.
  - LFSR = LFSR_SEED; ms counter 0; tick prescaler 0.
- Reset asserted mid-round aborts immediately to the reset values.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every clk cycle regardless of state; never all-zero.
- ms tick: prescaler counts 0..TICK_DIV-1 and pulses at wrap. The prescaler is cleared on every state entry, so the first tick comes TICK_DIV cycles after entry.
- States:
  - IDLE (0):
    - disp_sel 0.
    - start -> ARM with score cleared.
    - key_valid is ignored.
  - ARM (1):
    - On entry, latch delay = 250 + lfsr[8:0] ms (range 250-761).
    - On entry, latch candidate c = lfsr[4:0], minus 26 if c >= 26.
    - If c equals the previous goal_letter, use (c+1) mod 26. This guarantees the letter changes between rounds.
    - disp_sel 0, goal_show 0.
    - key_valid during ARM is a false start -> MISS.
    - Delay expiry -> PROMPT.
  - PROMPT (2):
    - On the entry cycle: timer_clr pulses, ms counter cleared, goal_show 1, disp_sel 1, timer_en 1.
    - key_valid with key_code == goal_letter -> HIT.
    - Any other key_valid -> MISS.
    - ms counter reaching TIMEOUT_MS -> MISS.
    - If key_valid and timeout coincide in one cycle, the key decides; timeout applies only when key_valid is 0.
  - HIT (3):
    - On entry: last_ms = ms count; if ms count < best_ms then best_ms = ms count (ties leave it unchanged).
    - On entry: score += 1, saturating at 255.
    - timer_en 0, disp_sel 3, goal_show 0.
    - After HOLD_MS -> ARM (next round).
  - MISS (4):
    - timer_en 0, disp_sel 2, goal_show 0.
    - After HOLD_MS -> IDLE.
    - score holds its value until the next start.
- Key and start handling outside the rules above:
  - start in any state other than IDLE is ignored.
  - key_valid in HIT or MISS is ignored.
- round_done: exactly one cycle, on the first cycle in HIT or MISS.
- Registered outputs: every output changes on the cycle after the causing input is sampled. Latency from key_valid to disp_sel update = 1 clk.
- ms counter: 11 bits, saturating at 2047. It counts only in ARM (against delay) and in PROMPT (against TIMEOUT_MS), and is cleared on every state entry.
- Encodings 5-7 of state_dbg are unreachable; if reached, the block returns to IDLE on the next cycle.

Decomposition:
- Package game_pkg:
  - state encoding constants IDLE/ARM/PROMPT/HIT/MISS;
  - NUM_LETTERS = 26;
  - disp_sel constants DISP_SCORE/DISP_LETTER/DISP_LOSS/DISP_HIT;
  - MS_W = 11;
  - ARM_BASE_MS = 250.
- One sub-module, lfsr16_gen (clk, rst, seed param, 16-bit out).
- Prescaler and FSM stay in round_sequencer.

Test Plan (TICK_DIV=10, TIMEOUT_MS=20, HOLD_MS=5):
- Reset then idle: rst pulse -> state_dbg 0, best_ms 2047, score 0. key_valid code 3 in IDLE -> no state change.
- Hit path: start; wait for timer_clr; after 7 ticks send key_valid with code = goal_letter -> state HIT next clk, round_done 1 for one cycle, last_ms 7, best_ms 7, score 1. After 50 clk -> ARM.
- Wrong key: in PROMPT send code (goal_letter+1) mod 26 -> MISS, disp_sel 2. After 50 clk -> IDLE with score held.
- Timeout: no key in PROMPT -> MISS exactly 200 clk (20 ticks) after timer_clr, timer_en drops.
- False start, letter change and coincidence:
  - key_valid during ARM -> MISS, timer_clr never pulses.
  - Over 20 consecutive hit rounds, goal_letter never repeats back-to-back and stays in 0-25.
  - Correct key on the same cycle the counter hits 20 -> HIT, last_ms 20.
- Saturation and mid-round reset:
  - 256 forced hits -> score stays 255.
  - rst asserted in PROMPT -> all outputs return to reset values in the same cycle, asynchronously.
